// File: rtl/blood_type_encoder_if.sv
// Strip-reader sample stream into the encoder, plus the encoded result and status back out.
interface blood_type_encoder_if;
  logic       start;
  logic       sample_valid;
  logic       sample_bit;
  logic       busy;
  logic [2:0] bloodType;
  logic       type_valid;
  logic       inconclusive;
  logic       timeout_err;

  modport master (
    output start,
    output sample_valid,
    output sample_bit,
    input  busy,
    input  bloodType,
    input  type_valid,
    input  inconclusive,
    input  timeout_err
  );

  modport slave (
    input  start,
    input  sample_valid,
    input  sample_bit,
    output busy,
    output bloodType,
    output type_valid,
    output inconclusive,
    output timeout_err
  );
endinterface

// File: rtl/blood_type_encoder.sv
// Serial 2-of-3 majority voter over anti-A, anti-B and anti-D wells, producing the 3-bit blood
// type code with a valid pulse, a non-unanimity flag and a reader-stall abort.
module blood_type_encoder #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  blood_type_encoder_if.slave bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StReadA  = 3'd1;
  localparam logic [2:0] StReadB  = 3'd2;
  localparam logic [2:0] StReadD  = 3'd3;
  localparam logic [2:0] StReport = 3'd4;

  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       well_cnt_q, well_cnt_d;
  logic [1:0]       tally_q, tally_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             maj_a_q, maj_a_d;
  logic             maj_b_q, maj_b_d;
  logic             split_a_q, split_a_d;
  logic             split_b_q, split_b_d;
  logic [2:0]       blood_type_q, blood_type_d;
  logic             inconclusive_q, inconclusive_d;
  logic             type_valid_q, type_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic             busy_q, busy_d;

  logic       in_read;
  logic       accept;
  logic       last_well;
  logic [1:0] tally_next;
  logic       maj_now;
  logic       split_now;
  logic       wait_expired;

  assign in_read      = (state_q == StReadA) || (state_q == StReadB) || (state_q == StReadD);
  assign accept       = in_read && bus.sample_valid;
  assign last_well    = (well_cnt_q == 2'd2);
  assign tally_next   = tally_q + {1'b0, bus.sample_bit};
  assign maj_now      = (tally_next >= 2'd2);
  assign split_now    = (tally_next != 2'd0) && (tally_next != 2'd3);
  assign wait_expired = in_read && !bus.sample_valid && (wait_cnt_q == WaitLast);

  always_comb begin
    state_d        = state_q;
    well_cnt_d     = well_cnt_q;
    tally_d        = tally_q;
    wait_cnt_d     = wait_cnt_q;
    maj_a_d        = maj_a_q;
    maj_b_d        = maj_b_q;
    split_a_d      = split_a_q;
    split_b_d      = split_b_q;
    blood_type_d   = blood_type_q;
    inconclusive_d = inconclusive_q;
    type_valid_d   = 1'b0;
    timeout_err_d  = 1'b0;
    busy_d         = busy_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StReadA;
          busy_d     = 1'b1;
          well_cnt_d = 2'd0;
          tally_d    = 2'd0;
          wait_cnt_d = '0;
        end
      end

      StReadA, StReadB, StReadD: begin
        if (accept) begin
          wait_cnt_d = '0;
          if (last_well) begin
            well_cnt_d = 2'd0;
            tally_d    = 2'd0;
            case (state_q)
              StReadA: begin
                maj_a_d   = maj_now;
                split_a_d = split_now;
                state_d   = StReadB;
              end
              StReadB: begin
                maj_b_d   = maj_now;
                split_b_d = split_now;
                state_d   = StReadD;
              end
              default: begin
                // Group field is {B present, A present} so that 01 reads as A and 10 as B.
                blood_type_d   = {maj_b_q, maj_a_q, maj_now};
                inconclusive_d = split_a_q | split_b_q | split_now;
                type_valid_d   = 1'b1;
                state_d        = StReport;
              end
            endcase
          end else begin
            well_cnt_d = well_cnt_q + 2'd1;
            tally_d    = tally_next;
          end
        end else if (wait_expired) begin
          // Abort drops partial votes but leaves the last good report on the outputs.
          state_d       = StIdle;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          well_cnt_d    = 2'd0;
          tally_d       = 2'd0;
          wait_cnt_d    = '0;
          maj_a_d       = 1'b0;
          maj_b_d       = 1'b0;
          split_a_d     = 1'b0;
          split_b_d     = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      StReport: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      well_cnt_q     <= 2'd0;
      tally_q        <= 2'd0;
      wait_cnt_q     <= '0;
      maj_a_q        <= 1'b0;
      maj_b_q        <= 1'b0;
      split_a_q      <= 1'b0;
      split_b_q      <= 1'b0;
      blood_type_q   <= 3'b000;
      inconclusive_q <= 1'b0;
      type_valid_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      well_cnt_q     <= well_cnt_d;
      tally_q        <= tally_d;
      wait_cnt_q     <= wait_cnt_d;
      maj_a_q        <= maj_a_d;
      maj_b_q        <= maj_b_d;
      split_a_q      <= split_a_d;
      split_b_q      <= split_b_d;
      blood_type_q   <= blood_type_d;
      inconclusive_q <= inconclusive_d;
      type_valid_q   <= type_valid_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.bloodType    = blood_type_q;
  assign bus.type_valid   = type_valid_q;
  assign bus.inconclusive = inconclusive_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_blood_type_encoder.sv
// Randomized bench for blood_type_encoder, checked against a vote-counting reference model.
module tb_blood_type_encoder;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blood_type_encoder_if bus();

  blood_type_encoder #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Last report the model believes is on the outputs.
  logic [2:0] last_bt  = 3'b000;
  logic       last_inc = 1'b0;

  // Observations from the most recent run_seq.
  int         r_lat;
  logic       r_got, r_busy_start, r_busy_rep, r_busy_after, r_tv_after, r_tmo;
  logic [2:0] r_bt;
  logic       r_inc;

  // Wells indexed 0..2 anti-A, 3..5 anti-B, 6..8 anti-D. Returns {inconclusive, bloodType}.
  function automatic logic [3:0] ref_model(input logic [8:0] w);
    int   ones;
    logic pos [3];
    logic split;
    int   grp;
    split = 1'b0;
    for (int r = 0; r < 3; r++) begin
      ones   = int'(w[3*r]) + int'(w[3*r+1]) + int'(w[3*r+2]);
      pos[r] = (ones * 2 > 3);
      if (ones % 3 != 0) split = 1'b1;
    end
    grp = 0;
    if (pos[0]) grp += 1;
    if (pos[1]) grp += 2;
    return {split, grp[1:0], pos[2]};
  endfunction

  function automatic int gap_sum(input logic [17:0] gaps);
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(gaps[2*i +: 2]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete test; ends in the cycle after REPORT with inputs idle.
  task automatic run_seq(input logic [8:0] w, input logic [17:0] gaps, input bit hold_start);
    int k;
    bus.start = 1'b1;
    step();
    r_busy_start = bus.busy;
    r_lat = 1;
    r_tmo = bus.timeout_err;
    if (!hold_start) bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      repeat (int'(gaps[2*i +: 2])) begin
        bus.sample_bit = 1'($urandom);
        step();
        r_lat++;
        r_tmo |= bus.timeout_err;
      end
      bus.sample_valid = 1'b1;
      bus.sample_bit   = w[i];
      step();
      r_lat++;
      r_tmo |= bus.timeout_err;
      bus.sample_valid = 1'b0;
    end
    k = 0;
    while (!bus.type_valid && k < 8) begin
      step();
      r_lat++;
      k++;
    end
    r_got      = bus.type_valid;
    r_bt       = bus.bloodType;
    r_inc      = bus.inconclusive;
    r_busy_rep = bus.busy;
    bus.start  = 1'b0;
    step();
    r_busy_after = bus.busy;
    r_tv_after   = bus.type_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_bit = 1'b0;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if ({bus.busy, bus.bloodType, bus.type_valid, bus.inconclusive, bus.timeout_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {bus.busy, bus.bloodType, bus.type_valid, bus.inconclusive, bus.timeout_err});
    end
  endtask

  task automatic test_a_pos();
    run_seq(9'b111_000_111, 18'd0, 1'b0);
    n_checks++;
    if (r_lat !== 10) begin
      n_fail++; $display("FAIL a_pos_latency: got %0d expected 10", r_lat);
    end
    n_checks++;
    if ({r_got, r_bt, r_inc} !== {1'b1, 3'b011, 1'b0}) begin
      n_fail++; $display("FAIL a_pos_report: got v=%b bt=%b inc=%b expected v=1 bt=011 inc=0",
                         r_got, r_bt, r_inc);
    end
    n_checks++;
    if ({r_busy_start, r_busy_rep, r_busy_after, r_tv_after} !== 4'b1100) begin
      n_fail++; $display("FAIL a_pos_busy: got %b expected 1100",
                         {r_busy_start, r_busy_rep, r_busy_after, r_tv_after});
    end
    last_bt = 3'b011; last_inc = 1'b0;
  endtask

  task automatic test_ab_neg_gaps();
    logic [17:0] gaps = {9{2'd2}};
    run_seq(9'b100_111_101, gaps, 1'b0);
    n_checks++;
    if ({r_got, r_bt, r_inc} !== {1'b1, 3'b110, 1'b1}) begin
      n_fail++; $display("FAIL ab_neg_report: got v=%b bt=%b inc=%b expected v=1 bt=110 inc=1",
                         r_got, r_bt, r_inc);
    end
    n_checks++;
    if (r_lat !== 10 + 18) begin
      n_fail++; $display("FAIL ab_neg_latency: got %0d expected 28", r_lat);
    end
    last_bt = 3'b110; last_inc = 1'b1;
  endtask

  task automatic test_timeout();
    int   k;
    logic busy_prev, tv_seen;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_bit = 1'($urandom);
      step();
      bus.sample_valid = 1'b0;
    end
    k = 1;
    busy_prev = 1'b0;
    tv_seen = 1'b0;
    while (!bus.timeout_err && k < 12) begin
      busy_prev = bus.busy;
      tv_seen |= bus.type_valid;
      step();
      k++;
    end
    n_checks++;
    if (k !== TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", k, TIMEOUT + 1);
    end
    n_checks++;
    if ({busy_prev, bus.busy, tv_seen, bus.type_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL timeout_busy: got %b expected 1000",
                         {busy_prev, bus.busy, tv_seen, bus.type_valid});
    end
    n_checks++;
    if ({bus.bloodType, bus.inconclusive} !== {last_bt, last_inc}) begin
      n_fail++; $display("FAIL timeout_hold: got %b expected %b",
                         {bus.bloodType, bus.inconclusive}, {last_bt, last_inc});
    end
    step();
    n_checks++;
    if (bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse_width: got %b expected 0", bus.timeout_err);
    end
  endtask

  task automatic test_timeout_edge();
    logic [8:0] w = 9'($urandom);
    logic [3:0] exp = ref_model(w);
    run_seq(w, {9{2'd3}}, 1'b0);
    n_checks++;
    if ({r_tmo, r_got, r_inc, r_bt} !== {1'b0, 1'b1, exp}) begin
      n_fail++; $display("FAIL timeout_edge: got tmo=%b v=%b inc_bt=%b expected tmo=0 v=1 inc_bt=%b",
                         r_tmo, r_got, {r_inc, r_bt}, exp);
    end
    n_checks++;
    if (r_lat !== 10 + 27) begin
      n_fail++; $display("FAIL timeout_edge_latency: got %0d expected 37", r_lat);
    end
    last_bt = exp[2:0]; last_inc = exp[3];
  endtask

  task automatic test_reset_mid();
    logic flag = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_bit = 1'b1;
      step();
    end
    bus.sample_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({bus.busy, bus.bloodType, bus.type_valid, bus.inconclusive, bus.timeout_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b expected 0000000",
                         {bus.busy, bus.bloodType, bus.type_valid, bus.inconclusive, bus.timeout_err});
    end
    for (int i = 0; i < int'(TIMEOUT) + 3; i++) begin
      step();
      flag |= bus.timeout_err | bus.type_valid | bus.busy;
    end
    n_checks++;
    if (flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_quiet: got %b expected 0", flag);
    end
    last_bt = 3'b000; last_inc = 1'b0;
    run_seq(9'b111_000_000, 18'd0, 1'b0);
    n_checks++;
    if ({r_got, r_bt, r_inc} !== {1'b1, 3'b001, 1'b0}) begin
      n_fail++; $display("FAIL o_pos_report: got v=%b bt=%b inc=%b expected v=1 bt=001 inc=0",
                         r_got, r_bt, r_inc);
    end
    last_bt = 3'b001; last_inc = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    logic       flag = 1'b0;
    logic [8:0] w = 9'($urandom);
    logic [3:0] exp = ref_model(w);
    logic [17:0] gaps;
    for (int i = 0; i < 9; i++) gaps[2*i +: 2] = 2'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_bit = 1'($urandom);
      step();
      flag |= bus.busy | bus.type_valid;
    end
    bus.sample_valid = 1'b0;
    n_checks++;
    if (flag !== 1'b0) begin
      n_fail++; $display("FAIL idle_samples: got busy/valid %b expected 0", flag);
    end
    run_seq(w, gaps, 1'b1);
    n_checks++;
    if ({r_got, r_inc, r_bt} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL start_held_report: got v=%b inc_bt=%b expected v=1 inc_bt=%b",
                         r_got, {r_inc, r_bt}, exp);
    end
    n_checks++;
    if (r_lat !== 10 + gap_sum(gaps)) begin
      n_fail++; $display("FAIL start_held_latency: got %0d expected %0d", r_lat, 10 + gap_sum(gaps));
    end
    flag = r_busy_after;
    for (int i = 0; i < 3; i++) begin
      step();
      flag |= bus.busy | bus.type_valid;
    end
    n_checks++;
    if (flag !== 1'b0 || {bus.inconclusive, bus.bloodType} !== exp) begin
      n_fail++; $display("FAIL no_extra_test: got busy=%b inc_bt=%b expected busy=0 inc_bt=%b",
                         flag, {bus.inconclusive, bus.bloodType}, exp);
    end
    last_bt = exp[2:0]; last_inc = exp[3];
  endtask

  task automatic test_back_to_back();
    logic [8:0]  w;
    logic [17:0] gaps;
    logic [3:0]  exp;
    for (int n = 0; n < 20; n++) begin
      w = 9'($urandom);
      for (int i = 0; i < 9; i++) gaps[2*i +: 2] = 2'($urandom_range(0, 3));
      if (n < 4) gaps = 18'd0;
      exp = ref_model(w);
      run_seq(w, gaps, 1'b0);
      n_checks++;
      if ({r_got, r_inc, r_bt} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL rand_report[%0d]: w=%b got v=%b inc_bt=%b expected v=1 inc_bt=%b",
                           n, w, r_got, {r_inc, r_bt}, exp);
      end
      n_checks++;
      if (r_lat !== 10 + gap_sum(gaps)) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d",
                           n, r_lat, 10 + gap_sum(gaps));
      end
      n_checks++;
      if ({r_busy_start, r_busy_rep, r_busy_after, r_tv_after, r_tmo} !== 5'b11000) begin
        n_fail++; $display("FAIL rand_handshake[%0d]: got %b expected 11000",
                           n, {r_busy_start, r_busy_rep, r_busy_after, r_tv_after, r_tmo});
      end
      last_bt = exp[2:0]; last_inc = exp[3];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_a_pos();
    test_ab_neg_gaps();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_ignored_inputs();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
